ff_pipe_slice: RTL and testbench



---
 rtl/ff_pipe_slice.sv | 148 ++++++++++++++
 tb/tb_ff_pipe_slice.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_pipe_slice.sv
// STAGES-deep valid/ready register pipeline with per-stage skid buffers, sync flush and occupancy count.
// Define FF_PIPE_RESET_DATA_EN to reset and flush-clear the data registers to RESET_VAL.
module ff_pipe_slice #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    count
);

  localparam int unsigned CW = $clog2(2*STAGES+1);

  if (STAGES < 1) begin : g_bad_stages
    $error("ff_pipe_slice: STAGES must be at least 1");
  end
  if ($bits(RESET_VAL) != WIDTH) begin : g_bad_reset_val
    $error("ff_pipe_slice: RESET_VAL width must equal WIDTH");
  end

  logic [STAGES-1:0] main_v_q, main_v_d;
  logic [STAGES-1:0] skid_v_q, skid_v_d;
  logic [WIDTH-1:0]  main_q [STAGES];
  logic [WIDTH-1:0]  main_d [STAGES];
  logic [WIDTH-1:0]  skid_q [STAGES];
  logic [WIDTH-1:0]  skid_d [STAGES];
  logic [CW-1:0]     count_q, count_d;
  logic              init_q;

  logic [STAGES-1:0] up_v;
  logic [STAGES-1:0] dn_rdy;
  logic [STAGES-1:0] push;
  logic [STAGES-1:0] pop;
  logic [WIDTH-1:0]  up_d [STAGES];
  logic              in_fire;
  logic              out_fire;

  // Stage i accepts whenever its skid is empty; that is its registered ready_up.
  for (genvar i = 0; i < STAGES; i++) begin : g_link
    if (i == 0) begin : g_head
      assign up_v[i] = in_valid & init_q;
      assign up_d[i] = in_data;
    end else begin : g_body
      assign up_v[i] = main_v_q[i-1];
      assign up_d[i] = main_q[i-1];
    end
    if (i == STAGES - 1) begin : g_tail
      assign dn_rdy[i] = out_ready;
    end else begin : g_inner
      assign dn_rdy[i] = ~skid_v_q[i+1];
    end
    assign push[i] = up_v[i] & ~skid_v_q[i];
    assign pop[i]  = main_v_q[i] & dn_rdy[i];
  end

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    for (int i = 0; i < STAGES; i++) begin
      if (skid_v_q[i]) begin
        if (pop[i]) begin
          main_d[i]   = skid_q[i];
          skid_v_d[i] = 1'b0;
        end
      end else if (push[i] && (!main_v_q[i] || pop[i])) begin
        main_d[i]   = up_d[i];
        main_v_d[i] = 1'b1;
      end else if (push[i]) begin
        skid_d[i]   = up_d[i];
        skid_v_d[i] = 1'b1;
      end else if (pop[i]) begin
        main_v_d[i] = 1'b0;
      end
    end
    if (flush) begin
      main_v_d = '0;
      skid_v_d = '0;
`ifdef FF_PIPE_RESET_DATA_EN
      main_d   = '{default: RESET_VAL};
      skid_d   = '{default: RESET_VAL};
`endif
    end
  end

  assign in_fire  = push[0];
  assign out_fire = pop[STAGES-1];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      count_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      count_q  <= count_d;
      init_q   <= 1'b1;
    end
  end

`ifdef FF_PIPE_RESET_DATA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '{default: RESET_VAL};
      skid_q <= '{default: RESET_VAL};
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
`endif

  // The flush term keeps in_ready high in a flush cycle even when the head skid is occupied.
  assign in_ready  = init_q & (~skid_v_q[0] | flush);
  assign out_valid = main_v_q[STAGES-1];
  assign out_data  = main_q[STAGES-1];
  assign count     = count_q;

endmodule

// File: tb/tb_ff_pipe_slice.sv
// Directed bench for ff_pipe_slice (STAGES=2, WIDTH=8, RESET_VAL=8'hA5).
module tb_ff_pipe_slice;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  ff_pipe_slice #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk);
    #2;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
`ifdef FF_PIPE_RESET_DATA_EN
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL reset_out_data got=%h exp=a5", out_data); end
`endif
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL release_in_ready_pre_edge got=%b exp=0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready_post_edge got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    int exp_cnt;
    out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_valid = (k <= 16);
      in_data  = 8'(k);
      if (k <= 16) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready); end
      end
      tick();
      exp_cnt = (k <= 1) ? k : (k <= 16) ? 2 : (k == 17) ? 1 : 0;
      tests++;
      if (out_valid !== (k >= 2 && k <= 17)) begin
        fails++; $display("FAIL stream_out_valid k=%0d got=%b exp=%b", k, out_valid, (k >= 2 && k <= 17));
      end
      tests++; if (int'(count) !== exp_cnt) begin fails++; $display("FAIL stream_count k=%0d got=%0d exp=%0d", k, count, exp_cnt); end
      if (k >= 2 && k <= 17) begin
        tests++;
        if (out_data !== 8'(k - 1)) begin fails++; $display("FAIL stream_out_data k=%0d got=%h exp=%h", k, out_data, 8'(k - 1)); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_stall();
    int accepted = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    for (int k = 0; k < 8; k++) begin
      if (in_valid && in_ready) begin
        accepted++;
        tick();
        in_data = in_data + 8'd1;
      end else begin
        tick();
      end
    end
    tests++; if (accepted !== 4) begin fails++; $display("FAIL stall_accepted got=%0d exp=4", accepted); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL stall_count got=%0d exp=4", count); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_out_valid k=%0d got=%b exp=1", k, out_valid); end
      tests++;
      if (out_data !== 8'(8'h20 + k)) begin fails++; $display("FAIL drain_out_data k=%0d got=%h exp=%h", k, out_data, 8'(8'h20 + k)); end
      tick();
      tests++; if (int'(count) !== 4 - k) begin fails++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count, 4 - k); end
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty_out_valid got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_random_bp();
    logic [7:0] sb[$];
    logic [7:0] exp_d;
    int         sent = 0;
    int         rcvd = 0;
    bit         ifire;
    bit         ofire;
    logic       r0;
    logic       r1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 8000 && rcvd < 1000; cyc++) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(0, 255));
      end
      out_ready = 1'b0;
      #1;
      r0 = in_ready;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      r1 = in_ready;
      tests++; if (r0 !== r1) begin fails++; $display("FAIL rand_ready_path cyc=%0d got=%b exp=%b", cyc, r1, r0); end
      ifire = in_valid && in_ready;
      ofire = out_valid && out_ready;
      if (ofire) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rand_underflow cyc=%0d got=%h exp=<none>", cyc, out_data);
        end else begin
          exp_d = sb.pop_front();
          if (out_data !== exp_d) begin fails++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_d); end
        end
        rcvd++;
      end
      if (ifire) begin
        sb.push_back(in_data);
        sent++;
      end
      @(posedge clk);
      #1;
      if (ifire) in_valid = 1'b0;
      tests++;
      if (int'(count) !== sb.size()) begin fails++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, sb.size()); end
    end
    tests++; if (rcvd !== 1000) begin fails++; $display("FAIL rand_beats got=%0d exp=1000", rcvd); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h41 + k);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_fill_ready k=%0d got=%b exp=1", k, in_ready); end
      tick();
    end
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_fill_count got=%0d exp=3", count); end
    flush   = 1'b1;
    in_data = 8'h44;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_cycle_in_ready got=%b exp=1", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count got=%0d exp=0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
`ifdef FF_PIPE_RESET_DATA_EN
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL flush_out_data got=%h exp=a5", out_data); end
`endif
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL post_flush_out_valid got=%b exp=1", out_valid); end
    tests++; if (out_data !== 8'h55) begin fails++; $display("FAIL post_flush_out_data got=%h exp=55", out_data); end
    tick();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL post_flush_count got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h61 + k);
      tick();
    end
    in_valid = 1'b0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL areset_fill_count got=%0d exp=3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL areset_count got=%0d exp=0", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
`ifdef FF_PIPE_RESET_DATA_EN
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL areset_out_data got=%h exp=a5", out_data); end
`endif
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL areset_release_pre got=%b exp=0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_release_post got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_post_out_valid got=%b exp=0", out_valid); end
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL areset_beat_valid got=%b exp=1", out_valid); end
    tests++; if (out_data !== 8'h77) begin fails++; $display("FAIL areset_beat_data got=%h exp=77", out_data); end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_random_bp();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
